booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Sequential signed multiplier for the Mini-SRC datapath, the counterpart of the restoring divider.
- Computes the full 2*WIDTH-bit two's-complement product of two WIDTH-bit operands using Booth recoding, one recoding step per clock.
- Result goes to the HI/LO register pair for the MUL instruction.
- The control unit drives a start/done handshake and stalls while busy is high.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  signed operand M; captured when start is accepted.
- multiplier  input  WIDTH  signed operand Q; captured when start is accepted.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; hi/lo are valid and new.
- hi  output  WIDTH  upper half of product.
- lo  output  WIDTH  lower half of product.

Behaviour:
- One clock. Reset is synchronous and active-high: clock and reset as named above; reset sampled on the rising edge of clock.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, step counter=0, internal registers=0.
- Reset has priority over all other inputs.
- Reset asserted mid-operation aborts immediately. No done pulse is produced for the aborted operation.
- States:
  - IDLE: wait for start. If start=1 at edge t: capture M and Q, clear the accumulator A, clear the Booth extra bit q(-1), counter=0, go to RUN. busy=1 from edge t onward.
  - RUN: one Booth step per edge.
    - The pair {Q[0], q(-1)} selects the action: 10 -> A=A-M; 01 -> A=A+M; 00/11 -> no add.
    - Then arithmetic-shift right {A,Q,q(-1)} by one.
    - A is WIDTH+2 bits internally, so that -M with M=-2^(WIDTH-1) cannot overflow.
    - After WIDTH steps (at edge t+WIDTH), load hi/lo from the low 2*WIDTH bits of {A,Q}, set busy=0, go to DONE.
  - DONE: done=1 for exactly this cycle. Next edge -> IDLE, done=0.
- Latency: start sampled at edge t -> done high during the cycle following edge t+WIDTH (t+WIDTH/2 with bit-pair recoding).
- Back-to-back: start is accepted again at the edge leaving DONE+1, i.e. only in IDLE.
- start during RUN or DONE is ignored. It is neither queued nor able to corrupt state.
- Operand inputs may change freely after acceptance; only the captured copies are used.
- hi/lo hold the previous result throughout RUN and change only at the completion edge. They hold until the next completion or reset.
- Product is exact for all operand pairs including both operands = -2^(WIDTH-1) (result +2^(2*WIDTH-2)). No overflow flag.

Optional Feature:
- Macro: BITPAIR_RECODE_EN.
- Defined: radix-4 bit-pair recoding on the triple {Q[1],Q[0],q(-1)}.
  - Digit set {0,+M,+2M,-M,-2M}.
  - Arithmetic shift right by two per step.
  - WIDTH/2 steps per operation. Latency and done timing scale accordingly.
  - The accumulator is wide enough that ±2M never overflows.
- Not defined: radix-2 Booth as above, WIDTH steps.
- Interface, reset values and handshake are identical in both builds.

Test Plan:
- Reset, then start with M=6, Q=7 at edge t -> busy=1 from t to t+32; done=1 only in the cycle after t+32; hi=0x00000000, lo=0x0000002A.
- M=-3 (0xFFFFFFFD), Q=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000. Also M=0x7FFFFFFF, Q=0x80000000 -> hi=0xC0000000, lo=0x80000000.
- Pulse start again at edge t+5 during RUN with different operands -> ignored; the original product completes at t+32. Previous hi/lo stay stable until that edge.
- Assert reset at edge t+10 mid-operation -> busy, done, hi and lo read 0 after that edge. No done pulse follows. A fresh start then completes normally.
- Build with BITPAIR_RECODE_EN and rerun all vectors above -> identical hi/lo values, with done in the cycle after edge t+16.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential signed Booth multiplier: WIDTH steps (WIDTH/2 with BITPAIR_RECODE_EN), start accepted only in IDLE.
// busy high during RUN, done pulses one cycle with new hi/lo; start outside IDLE is dropped.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef BITPAIR_RECODE_EN
  localparam int AW    = WIDTH + 3;
  localparam int STEPS = WIDTH / 2;
`else
  localparam int AW    = WIDTH + 2;
  localparam int STEPS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    acc, acc_nxt, mx, addend, sum;
  logic [WIDTH-1:0] m_reg, q_reg, q_nxt;
  logic             qm1, qm1_nxt;
  logic [CW-1:0]    cnt;
  logic             last;

  assign mx   = {{(AW-WIDTH){m_reg[WIDTH-1]}}, m_reg};
  assign last = (cnt == CW'(STEPS - 1));

  // One recoding step: add the selected multiple of M, then shift {A,Q,q(-1)} arithmetically.
  always_comb begin
    addend = '0;
`ifdef BITPAIR_RECODE_EN
    case ({q_reg[1:0], qm1})
      3'b001, 3'b010: addend = mx;
      3'b011:         addend = mx << 1;
      3'b100:         addend = -(mx << 1);
      3'b101, 3'b110: addend = -mx;
      default:        addend = '0;
    endcase
    sum     = acc + addend;
    acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt   = {sum[1:0], q_reg[WIDTH-1:2]};
    qm1_nxt = q_reg[1];
`else
    case ({q_reg[0], qm1})
      2'b10:   addend = -mx;
      2'b01:   addend = mx;
      default: addend = '0;
    endcase
    sum     = acc + addend;
    acc_nxt = {sum[AW-1], sum[AW-1:1]};
    q_nxt   = {sum[0], q_reg[WIDTH-1:1]};
    qm1_nxt = q_reg[0];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      m_reg <= '0;
      q_reg <= '0;
      acc   <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          acc   <= acc_nxt;
          q_reg <= q_nxt;
          qm1   <= qm1_nxt;
          cnt   <= cnt + CW'(1);
          // hi/lo only move on the completing step so the previous product stays visible.
          if (last) begin
            hi <= acc_nxt[WIDTH-1:0];
            lo <= q_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomised plus directed bench for booth_mul_seq against a cycle-level behavioural model.
module tb_booth_mul_seq;
  localparam int W = 32;
`ifdef BITPAIR_RECODE_EN
  localparam int STEPS = W / 2;
`else
  localparam int STEPS = W;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: a countdown plus a plain 64-bit signed product.
  logic                  m_busy = 1'b0, m_done = 1'b0;
  logic [W-1:0]          m_hi = '0, m_lo = '0;
  logic signed [2*W-1:0] m_pend = '0;
  int                    m_left = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_pend[2*W-1:W];
        m_lo   <= m_pend[W-1:0];
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_left <= STEPS;
      m_pend <= $signed({{W{multiplicand[W-1]}}, multiplicand}) *
                $signed({{W{multiplier[W-1]}}, multiplier});
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", {63'd0, busy}, {63'd0, m_busy});
      check("done", {63'd0, done}, {63'd0, m_done});
      check("hi", {32'd0, hi}, {32'd0, m_hi});
      check("lo", {32'd0, lo}, {32'd0, m_lo});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom % 6)
      0: v = 32'h8000_0000;
      1: v = 32'h7FFF_FFFF;
      2: v = '0;
      3: v = '1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Assert start for one edge, then scramble operands to prove they were captured.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; multiplicand = a; multiplier = b;
    tick();
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
  endtask

  task automatic wait_done(input bit noisy, output int lat);
    lat = -1;
    for (int i = 1; i <= STEPS + 8; i++) begin
      if (noisy) begin
        start = ($urandom % 4 == 0); multiplicand = $urandom; multiplier = $urandom;
      end
      tick();
      if (done === 1'b1) begin lat = i; break; end
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat;
    launch(a, b);
    wait_done(1'b0, lat);
    check({nm, " latency"}, 64'(lat), 64'(STEPS));
    check({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
    check({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    tick();
  endtask

  initial begin
    int lat, ndone;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    tick();

    run_op("6x7", 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A);
    check("model 6x7 lo", {32'd0, m_lo}, 64'h2A);
    run_op("-3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("min x min", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    check("model minxmin hi", {32'd0, m_hi}, 64'h4000_0000);
    run_op("max x min", 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);

    // Start pulse five edges into RUN must be ignored.
    launch(32'd6, 32'd7);
    repeat (4) tick();
    start = 1'b1; multiplicand = 32'h1234_5678; multiplier = 32'h0BAD_F00D;
    tick();
    start = 1'b0;
    check("ignored start hi held", {32'd0, hi}, 64'hC000_0000);
    wait_done(1'b0, lat);
    check("ignored start latency", 64'(lat), 64'(STEPS - 5));
    check("ignored start lo", {32'd0, lo}, 64'h2A);
    tick();

    // Reset ten edges into RUN aborts with no done pulse.
    launch(32'hFFFF_FFFD, 32'd5);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    ndone = 0;
    repeat (STEPS + 4) begin tick(); if (done === 1'b1) ndone++; end
    check("abort no done", 64'(ndone), 64'd0);
    run_op("after abort", 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      launch(pick(), pick());
      wait_done(1'b1, lat);
      check("random latency", 64'(lat), 64'(STEPS));
      tick();
    end

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
